// File: rtl/sha1_msg_sequencer.sv
// SHA-1 front end: packs a 32-bit word stream into padded 512-bit blocks and drives the core block by block.
// Optional RUN watchdog is compiled in with `define SHA1_MSG_SEQUENCER_WATCHDOG_EN.
module sha1_msg_sequencer #(
  parameter int BlockWidth     = 512,
  parameter int DigestWidth    = 160,
  parameter int WatchdogCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            s_data_i,
  input  logic                   s_valid_i,
  input  logic                   s_last_i,
  input  logic [1:0]             s_bytes_i,
  output logic                   s_ready_o,
  output logic [BlockWidth-1:0]  block_o,
  output logic                   enable_hash_o,
  output logic                   rst_hash_o,
  input  logic                   hold_i,
  input  logic                   idle_i,
  input  logic [DigestWidth-1:0] core_digest_i,
  input  logic                   core_digest_valid_i,
  output logic [DigestWidth-1:0] digest_o,
  output logic                   digest_valid_o,
  input  logic                   digest_ready_i,
  output logic                   busy_o,
  output logic                   error_o
);

  typedef enum logic [2:0] {S_INIT, S_FILL, S_PAD, S_ISSUE, S_RUN, S_OUT} state_e;

  state_e                  state_q, state_d;
  logic [0:15][31:0]       buf_q, buf_d;
  logic [3:0]              widx_q, widx_d;
  logic [63:0]             bitcnt_q, bitcnt_d;
  logic                    pad80_q, pad80_d;
  logic                    pad_pend_q, pad_pend_d;
  logic                    final_q, final_d;
  logic [DigestWidth-1:0]  digest_q, digest_d;
  logic                    error_q, error_d;
  logic                    rst_hash_q, rst_hash_d;

  logic [31:0]             last_word;
  logic [2:0]              nbytes;

`ifdef SHA1_MSG_SEQUENCER_WATCHDOG_EN
  localparam int WdW = $clog2(WatchdogCycles);
  logic [WdW-1:0]          wd_q, wd_d;
`endif

  // Tail word of the message: keep the valid bytes and place the 0x80 marker right behind them.
  always_comb begin
    nbytes = (s_bytes_i == 2'd0) ? 3'd4 : {1'b0, s_bytes_i};
    case (s_bytes_i)
      2'd1:    last_word = {s_data_i[31:24], 24'h800000};
      2'd2:    last_word = {s_data_i[31:16], 16'h8000};
      2'd3:    last_word = {s_data_i[31:8], 8'h80};
      default: last_word = s_data_i;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    buf_d          = buf_q;
    widx_d         = widx_q;
    bitcnt_d       = bitcnt_q;
    pad80_d        = pad80_q;
    pad_pend_d     = pad_pend_q;
    final_d        = final_q;
    digest_d       = digest_q;
    error_d        = error_q;
    rst_hash_d     = 1'b0;
    s_ready_o      = 1'b0;
    enable_hash_o  = 1'b0;
    digest_valid_o = 1'b0;
`ifdef SHA1_MSG_SEQUENCER_WATCHDOG_EN
    wd_d           = (state_q == S_RUN) ? wd_q + 1'b1 : '0;
`endif
    case (state_q)
      S_INIT: begin
        buf_d      = '0;
        widx_d     = '0;
        bitcnt_d   = '0;
        pad80_d    = 1'b0;
        pad_pend_d = 1'b0;
        final_d    = 1'b0;
        if (idle_i) state_d = S_FILL;
      end
      S_FILL: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          widx_d = widx_q + 4'd1;
          if (s_last_i) begin
            bitcnt_d      = bitcnt_q + {58'd0, nbytes, 3'd0};
            buf_d[widx_q] = last_word;
            pad80_d       = (nbytes == 3'd4);
            // Marker in word 14/15 leaves no room for the length: a second block follows.
            pad_pend_d    = (widx_q >= 4'd14);
            final_d       = 1'b0;
            state_d       = (widx_q == 4'd15) ? S_ISSUE : S_PAD;
          end else begin
            bitcnt_d      = bitcnt_q + 64'd32;
            buf_d[widx_q] = s_data_i;
            final_d       = 1'b0;
            if (widx_q == 4'd15) state_d = S_ISSUE;
          end
        end else if (s_last_i && widx_q == 4'd0) begin
          // Zero-length tail: the marker starts a fresh block.
          pad80_d = 1'b1;
          state_d = S_PAD;
        end
      end
      S_PAD: begin
        widx_d = widx_q + 4'd1;
        if (pad80_q) begin
          buf_d[widx_q] = 32'h8000_0000;
          pad80_d       = 1'b0;
          if (widx_q >= 4'd14) pad_pend_d = 1'b1;
        end else if (!pad_pend_q && widx_q == 4'd14) begin
          buf_d[widx_q] = bitcnt_q[63:32];
        end else if (!pad_pend_q && widx_q == 4'd15) begin
          buf_d[widx_q] = bitcnt_q[31:0];
        end else begin
          buf_d[widx_q] = '0;
        end
        if (widx_q == 4'd15) begin
          state_d = S_ISSUE;
          final_d = !pad_pend_d;
        end
      end
      S_ISSUE: begin
        enable_hash_o = 1'b1;
        state_d       = S_RUN;
      end
      S_RUN: begin
        // Drop enable while the core holds so it never re-latches the old block.
        enable_hash_o = ~hold_i;
        if (core_digest_valid_i) begin
          if (final_q) begin
            digest_d = core_digest_i;
            state_d  = S_OUT;
          end else begin
            error_d    = 1'b1;
            rst_hash_d = 1'b1;
            state_d    = S_INIT;
          end
        end else if (hold_i) begin
          if (final_q) begin
            digest_d = core_digest_i;
            state_d  = S_OUT;
          end else begin
            buf_d      = '0;
            widx_d     = '0;
            pad_pend_d = 1'b0;
            state_d    = pad_pend_q ? S_PAD : S_FILL;
          end
        end
`ifdef SHA1_MSG_SEQUENCER_WATCHDOG_EN
        else if (wd_q == WdW'(WatchdogCycles - 1)) begin
          error_d    = 1'b1;
          rst_hash_d = 1'b1;
          state_d    = S_INIT;
        end
`endif
      end
      S_OUT: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i) begin
          rst_hash_d = 1'b1;
          state_d    = S_INIT;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      buf_q      <= '0;
      widx_q     <= '0;
      bitcnt_q   <= '0;
      pad80_q    <= 1'b0;
      pad_pend_q <= 1'b0;
      final_q    <= 1'b0;
      digest_q   <= '0;
      error_q    <= 1'b0;
      rst_hash_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      widx_q     <= widx_d;
      bitcnt_q   <= bitcnt_d;
      pad80_q    <= pad80_d;
      pad_pend_q <= pad_pend_d;
      final_q    <= final_d;
      digest_q   <= digest_d;
      error_q    <= error_d;
      rst_hash_q <= rst_hash_d;
    end
  end

`ifdef SHA1_MSG_SEQUENCER_WATCHDOG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  assign block_o    = buf_q;
  assign digest_o   = digest_q;
  assign error_o    = error_q;
  assign rst_hash_o = rst_hash_q;
  assign busy_o     = !(state_q == S_INIT || (state_q == S_FILL && widx_q == 4'd0));

endmodule

// File: tb/tb_sha1_msg_sequencer.sv
// Directed bench for sha1_msg_sequencer with a behavioural SHA-1 core and block/digest scoreboards.
module tb_sha1_msg_sequencer;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  s_data_i = '0;
  logic         s_valid_i = 1'b0, s_last_i = 1'b0;
  logic [1:0]   s_bytes_i = '0;
  logic         s_ready_o;
  logic [511:0] block_o;
  logic         enable_hash_o, rst_hash_o;
  logic         hold_i, idle_i;
  logic [159:0] core_digest_i;
  logic         core_digest_valid_i;
  logic [159:0] digest_o;
  logic         digest_valid_o;
  logic         digest_ready_i = 1'b0;
  logic         busy_o, error_o;

  sha1_msg_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_last_i(s_last_i), .s_bytes_i(s_bytes_i), .s_ready_o(s_ready_o), .block_o(block_o),
    .enable_hash_o(enable_hash_o), .rst_hash_o(rst_hash_o), .hold_i(hold_i), .idle_i(idle_i),
    .core_digest_i(core_digest_i), .core_digest_valid_i(core_digest_valid_i),
    .digest_o(digest_o), .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i),
    .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  localparam int HASH_CYC = 12;
  localparam logic [159:0] H0 = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  int total = 0, bad = 0;
  logic [511:0] blk_q[$];
  logic [159:0] dig_q[$];

  task automatic chk_v(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    assert (got === exp) else begin bad++; $error("FAIL %s: got %0h want %0h", tag, got, exp); end
  endtask
  task automatic chk_b(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin bad++; $error("FAIL %s: got %b want %b", tag, got, exp); end
  endtask
  task automatic chk_i(input string tag, input int got, input int exp);
    total++;
    assert (got == exp) else begin bad++; $error("FAIL %s: got %0d want %0d", tag, got, exp); end
  endtask

  function automatic logic [159:0] sha1_comp(input logic [159:0] h, input logic [511:0] b);
    logic [31:0] w[80];
    logic [31:0] a, bb, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, bb, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (bb & c) | (~bb & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = bb ^ c ^ d;                    k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = bb ^ c ^ d;                    k = 32'hca62c1d6; end
      t  = {a[26:0], a[31:27]} + f + e + k + w[i];
      e  = d; d = c; c = {bb[1:0], bb[31:2]}; bb = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + bb, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Behavioural core: latches on enable in IDLE/DONE, hashes HASH_CYC cycles, then holds.
  typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE} cst_e;
  cst_e         cst = C_IDLE;
  logic [159:0] h_q = H0;
  int           ccnt = 0, nlatch = 0;
  logic         dv_mode = 1'b0, dead = 1'b0;

  assign hold_i              = (cst == C_DONE);
  assign idle_i              = (cst == C_IDLE);
  assign core_digest_valid_i = dv_mode && (cst == C_DONE);
  assign core_digest_i       = h_q;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cst <= C_IDLE; h_q <= H0; ccnt <= 0;
    end else if (rst_hash_o) begin
      cst <= C_IDLE; h_q <= H0;
    end else begin
      case (cst)
        C_IDLE, C_DONE: if (enable_hash_o) begin
          chk_i("blk_expected", (blk_q.size() > 0) ? 1 : 0, 1);
          if (blk_q.size() > 0) chk_v("block", block_o, blk_q.pop_front());
          h_q <= sha1_comp(h_q, block_o); cst <= C_BUSY; ccnt <= 0; nlatch <= nlatch + 1;
        end
        default: if (!dead) begin
          ccnt <= ccnt + 1;
          if (ccnt == HASH_CYC - 1) cst <= C_DONE;
        end
      endcase
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (s_ready_o !== 1'b1 && n < 3000) begin tick(); n++; end
    chk_i("ready_wait_bound", (n < 3000) ? 1 : 0, 1);
  endtask

  task automatic drive_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
    s_data_i = d; s_valid_i = 1'b1; s_last_i = last; s_bytes_i = nb;
    wait_ready();
    tick();
    s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = '0; s_bytes_i = '0;
  endtask

  // Standard padding built independently; pushes every expected block and the expected digest.
  task automatic expect_msg(input logic [7:0] m[$], input logic [159:0] dig, input bit use_ref);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    logic [159:0] h;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    h = H0;
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi+j];
      blk_q.push_back(blk);
      h = sha1_comp(h, blk);
    end
    dig_q.push_back(use_ref ? h : dig);
  endtask

  // Bytes past the end of the last word are driven as 0xEE; the design must mask them.
  task automatic send_msg(input logic [7:0] m[$]);
    int n, nw;
    logic [31:0] w;
    n  = m.size();
    nw = (n + 3) / 4;
    if (n == 0) begin
      wait_ready();
      s_last_i = 1'b1; tick(); s_last_i = 1'b0;
      return;
    end
    for (int i = 0; i < nw; i++) begin
      for (int j = 0; j < 4; j++) w[31-8*j -: 8] = (4*i + j < n) ? m[4*i+j] : 8'hEE;
      drive_word(w, i == nw - 1, 2'(n % 4));
    end
  endtask

  task automatic get_digest(input int stall);
    int n = 0, pulses = 0;
    logic [159:0] exp, d0;
    while (digest_valid_o !== 1'b1 && n < 5000) begin tick(); n++; end
    chk_i("digest_wait_bound", (n < 5000) ? 1 : 0, 1);
    exp = (dig_q.size() > 0) ? dig_q.pop_front() : '0;
    chk_v("digest", 512'(digest_o), 512'(exp));
    chk_b("busy_in_out", busy_o, 1'b1);
    chk_b("sready_in_out", s_ready_o, 1'b0);
    chk_i("blocks_left", blk_q.size(), 0);
    d0 = digest_o;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk_b("stall_valid", digest_valid_o, 1'b1);
      chk_v("stall_digest", 512'(digest_o), 512'(d0));
      chk_b("stall_sready", s_ready_o, 1'b0);
    end
    digest_ready_i = 1'b1; tick(); digest_ready_i = 1'b0;
    chk_b("valid_dropped", digest_valid_o, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (rst_hash_o === 1'b1) pulses++;
      tick();
    end
    chk_i("rst_hash_pulses", pulses, 1);
  endtask

  initial begin
    logic [7:0]   m[$];
    logic [7:0]   mabc[$];
    logic [511:0] blk;
    string        s56;
    int           n, base;
    int           lens[8] = '{1, 4, 55, 58, 60, 62, 64, 119};

    mabc = '{8'h61, 8'h62, 8'h63};
    s56  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

    tick(2);
    chk_b("rst_sready", s_ready_o, 1'b0);
    chk_b("rst_enable", enable_hash_o, 1'b0);
    chk_b("rst_rst_hash", rst_hash_o, 1'b1);
    chk_b("rst_dvalid", digest_valid_o, 1'b0);
    chk_b("rst_busy", busy_o, 1'b0);
    chk_b("rst_error", error_o, 1'b0);
    chk_v("rst_digest", 512'(digest_o), '0);
    chk_v("rst_block", block_o, '0);
    rst_i = 1'b0;

    // "abc" with the digest consumer stalled for 20 cycles
    expect_msg(mabc, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, 1'b0);
    send_msg(mabc);
    get_digest(20);

    m.delete();
    expect_msg(m, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709, 1'b0);
    send_msg(m);
    get_digest(0);

    for (int i = 0; i < s56.len(); i++) m.push_back(s56[i]);
    expect_msg(m, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1, 1'b0);
    send_msg(m);
    get_digest(0);

    // Lengths that put the marker/length at every awkward word position
    foreach (lens[k]) begin
      m.delete();
      for (int i = 0; i < lens[k]; i++) m.push_back(8'($urandom_range(0, 255)));
      expect_msg(m, '0, 1'b1);
      send_msg(m);
      get_digest(0);
    end

    // Core reporting digest_valid together with hold on the final block
    dv_mode = 1'b1;
    expect_msg(mabc, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, 1'b0);
    send_msg(mabc);
    get_digest(0);
    chk_b("no_error_final_dv", error_o, 1'b0);

    // digest_valid on a non-final block is an error
    m.delete();
    for (int i = 0; i < s56.len(); i++) m.push_back(s56[i]);
    expect_msg(m, '0, 1'b1);
    send_msg(m);
    n = 0;
    while (error_o !== 1'b1 && n < 2000) begin tick(); n++; end
    chk_i("error_wait_bound", (n < 2000) ? 1 : 0, 1);
    tick(3);
    chk_b("busy_after_err", busy_o, 1'b0);
    chk_b("ready_after_err", s_ready_o, 1'b1);
    chk_b("no_digest_after_err", digest_valid_o, 1'b0);
    blk_q.delete(); dig_q.delete();
    dv_mode = 1'b0;

    expect_msg(mabc, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, 1'b0);
    send_msg(mabc);
    get_digest(0);
    chk_b("error_sticky", error_o, 1'b1);

    // Reset while the core is hashing block 2 of a longer message
    base = nlatch;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = $urandom;
      blk_q.push_back(blk);
      for (int i = 0; i < 16; i++) drive_word(blk[511-32*i -: 32], 1'b0, 2'd0);
    end
    n = 0;
    while (nlatch != base + 2 && n < 2000) begin tick(); n++; end
    chk_i("blk2_wait_bound", (n < 2000) ? 1 : 0, 1);
    tick(3);
    rst_i = 1'b1; #2;
    chk_b("midrst_sready", s_ready_o, 1'b0);
    chk_b("midrst_enable", enable_hash_o, 1'b0);
    chk_b("midrst_rst_hash", rst_hash_o, 1'b1);
    chk_b("midrst_busy", busy_o, 1'b0);
    chk_b("midrst_error", error_o, 1'b0);
    chk_v("midrst_block", block_o, '0);
    chk_v("midrst_digest", 512'(digest_o), '0);
    tick(); rst_i = 1'b0;
    blk_q.delete(); dig_q.delete();
    expect_msg(mabc, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, 1'b0);
    send_msg(mabc);
    get_digest(0);

`ifdef SHA1_MSG_SEQUENCER_WATCHDOG_EN
    dead = 1'b1;
    expect_msg(mabc, '0, 1'b1);
    send_msg(mabc);
    n = 0;
    while (error_o !== 1'b1 && n < 1000) begin tick(); n++; end
    chk_i("wd_time_window", (n >= 250 && n < 400) ? 1 : 0, 1);
    chk_b("wd_rst_hash", rst_hash_o, 1'b1);
    tick(3);
    chk_b("wd_busy", busy_o, 1'b0);
    chk_b("wd_ready", s_ready_o, 1'b1);
    dead = 1'b0;
    blk_q.delete(); dig_q.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha1_msg_sequencer.md
Name: sha1_msg_sequencer

Overview:
- Front-end controller for the SHA-1 core.
- Accepts an arbitrary-length byte message as a 32-bit word stream and builds 512-bit blocks with standard SHA-1 padding (0x80, zeros, 64-bit big-endian bit length).
- Sequences the core's enable/reset handshake block by block, captures the final 160-bit digest, and presents it on a valid/ready output.
- Sits between the bus/stream wrapper and the SHA-1 core.

Parameters:
- BlockWidth, 512, block width driven to the core; fixed at 16 words.
- DigestWidth, 160, digest width.
- WatchdogCycles, 256, max cycles in RUN without a core response; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- s_data_i  in  32  message word; first byte in [31:24]
- s_valid_i  in  1  word valid
- s_last_i  in  1  final word of message
- s_bytes_i  in  2  valid bytes in last word; 0 means 4; ignored unless s_last_i
- s_ready_o  out  1  word accepted when s_valid_i & s_ready_o
- block_o  out  512  block to core; word 0 in [511:480]
- enable_hash_o  out  1  core enable
- rst_hash_o  out  1  core hash reset
- hold_i  in  1  core in HOLD
- idle_i  in  1  core in IDLE
- core_digest_i  in  160  core digest
- core_digest_valid_i  in  1  core digest valid
- digest_o  out  160  final digest
- digest_valid_o  out  1  digest valid
- digest_ready_i  in  1  digest consumed
- busy_o  out  1  message in progress
- error_o  out  1  sticky error

Behaviour:
- Reset values: all outputs 0, except rst_hash_o=1. Buffer, word index, 64-bit bit counter and state are cleared.
- States: INIT, FILL, PAD, ISSUE, RUN, OUT.
- INIT:
  - rst_hash_o=1 for one cycle.
  - Moves to FILL once idle_i=1.
- FILL:
  - s_ready_o=1.
  - Each accepted word is written to buffer[widx], widx increments, and the bit counter adds 32.
  - If widx reaches 16 without last: go to ISSUE.
  - On last with b bytes (b = 1..4), the bit counter adds 8*b.
    - b<4: bytes after the data in the same word become 0x80 then zeros.
    - b=4: 0x80000000 goes into the next word, or the next block if widx=15.
  - Then go to PAD.
- PAD:
  - Writes one word per cycle; s_ready_o=0.
  - Writes zeros up to word 13, then bit count [63:32] in word 14 and [31:0] in word 15, then ISSUE.
  - If the padding word lands at index 14 or 15: zero-fill to word 15, ISSUE, then a second block of zeros plus length. A pad_pending flag tracks this.
- ISSUE:
  - block_o stable; enable_hash_o=1 for exactly this cycle; next state RUN.
- RUN:
  - enable_hash_o = ~hold_i, so the core never re-latches a stale block in HOLD.
  - hold_i=1 with a non-final block: clear buffer and widx, go to FILL (or PAD if pad_pending).
  - hold_i=1 or core_digest_valid_i=1 with the final block: register core_digest_i into digest_o, go to OUT.
  - core_digest_valid_i=1 on a non-final block: set error_o, capture nothing, go to INIT.
- OUT:
  - digest_valid_o=1, held until digest_ready_i.
  - On handshake: rst_hash_o pulses 1 cycle, go to INIT.
  - digest_o is stable while valid.
- Latency:
  - One cycle per accepted word.
  - One cycle per pad word.
  - One ISSUE cycle.
  - Core hashing time.
  - One capture cycle.
- busy_o=1 in all states except INIT and FILL-with-widx=0.
- Bit counter: wraps modulo 2^64, with no error.
- Empty message: s_last_i with s_bytes_i=0 and an all-zero word is not an empty message. Empty messages are signalled by a zero-length start: s_valid_i=0, s_last_i=1 in FILL at widx=0; this writes 0x80 at word 0.
- Simultaneous hold_i and core_digest_valid_i: treated as core_digest_valid_i.
- Reset mid-operation:
  - All state is lost; rst_hash_o=1 returns the core to IDLE.
  - error_o clears only on rst_i.

Optional Feature:
- Macro: SHA1_MSG_SEQUENCER_WATCHDOG_EN.
- With the macro: a counter runs in RUN. If no response arrives within WatchdogCycles:
  - error_o=1.
  - rst_hash_o pulses.
  - State goes to INIT and the message is discarded.
- Without the macro: no counter; RUN waits indefinitely; WatchdogCycles is unused.

Test Plan:
- "abc" as one word 0x61626300 with s_bytes_i=3, last:
  - block word 0 = 0x61626380, word 15 = 0x00000018.
  - digest_o = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- Empty message:
  - block word 0 = 0x80000000, words 14/15 = 0.
  - digest_o = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- 56-byte "abcdbcdecdef...nopq" (14 words, last with s_bytes_i=0):
  - Two blocks; second block word 15 = 0x000001c0.
  - digest_o = 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- Backpressure: digest_ready_i held 0 for 20 cycles:
  - digest_valid_o stays 1 with digest_o constant.
  - s_ready_o stays 0.
  - rst_hash_o pulses exactly once after the handshake.
- rst_i asserted during RUN of block 2 of 3, then "abc" is sent:
  - All outputs return to reset values.
  - Correct "abc" digest results.
- Watchdog (macro on): hold_i and core_digest_valid_i tied 0:
  - error_o=1 after WatchdogCycles in RUN.
  - rst_hash_o pulses.
  - State returns to INIT.
